// File: rtl/seg_scan_capture.sv
// Receive side of an 8-digit multiplexed seven-segment scan: rebuilds digit patterns and checks scan order.
// Define CAPTURE_DP_EN to capture the decimal point (seg_n[7]); otherwise it is ignored and reads as 0.
module seg_scan_capture #(
   parameter int SETTLE = 2,
   parameter int ERRW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      anode_n,
   input  logic [7:0]      seg_n,
   output logic [63:0]     digit_seg,
   output logic [2:0]      cur_digit,
   output logic            frame_done,
   output logic            locked,
   output logic            anode_err,
   output logic            seq_err,
   output logic [ERRW-1:0] err_count
);
   typedef enum logic {HUNT, TRACK} state_t;

`ifdef CAPTURE_DP_EN
   localparam logic [7:0] SEG_MASK = 8'hFF;
`else
   localparam logic [7:0] SEG_MASK = 8'h7F;
`endif
   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   logic [7:0]      anode_q, anode_prev_q, seg_q, seg_prev_q, seg_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            done_q, done_d;
   state_t          state_q, state_d;
   logic [2:0]      expect_q, expect_d;
   logic [7:0][7:0] digit_seg_q, digit_seg_d;
   logic [2:0]      cur_digit_q, cur_digit_d;
   logic            frame_done_q, frame_done_d;
   logic            anode_err_q, anode_err_d;
   logic            seq_err_q, seq_err_d;
   logic [ERRW-1:0] err_count_q, err_count_d;
   logic [2:0]      idx;
   logic [3:0]      nlow;
   logic            code_valid, code_illegal, same, strobe;

   // Segments are kept active-high; a masked DP bit stays 0 so it never affects stability.
   assign seg_d = ~seg_n & SEG_MASK;

   always_comb begin
      idx  = '0;
      nlow = '0;
      for (int i = 0; i < 8; i++) begin
         if (!anode_q[i]) begin
            idx  = 3'(i);
            nlow = nlow + 4'd1;
         end
      end
      code_valid   = (nlow == 4'd1);
      code_illegal = !code_valid && (anode_q != 8'hFF);
      same         = (anode_q == anode_prev_q) && (seg_q == seg_prev_q);
      strobe       = same && (cnt_q == SETTLE_C) && code_valid && !done_q;

      if (!same)                cnt_d = '0;
      else if (cnt_q < SETTLE_C) cnt_d = cnt_q + 4'd1;
      else                      cnt_d = cnt_q;
      done_d = same && (done_q || strobe);

      anode_err_d  = code_illegal && (anode_q != anode_prev_q);
      state_d      = state_q;
      expect_d     = expect_q;
      frame_done_d = 1'b0;
      seq_err_d    = 1'b0;
      digit_seg_d  = digit_seg_q;
      cur_digit_d  = cur_digit_q;
      if (strobe) begin
         digit_seg_d[idx] = seg_q;
         cur_digit_d      = idx;
         if (state_q == HUNT) begin
            if (idx == 3'd0) begin
               state_d  = TRACK;
               expect_d = 3'd1;
            end
         end else if (idx == expect_q) begin
            expect_d     = expect_q + 3'd1;
            frame_done_d = (idx == 3'd7);
         end else begin
            // Out-of-order digit drops lock; a digit 0 here does not relock until the next one.
            seq_err_d = 1'b1;
            state_d   = HUNT;
         end
      end

      err_count_d = err_count_q;
      if ((anode_err_d || seq_err_d) && (err_count_q != '1))
         err_count_d = err_count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anode_q      <= 8'hFF;
         anode_prev_q <= 8'hFF;
         seg_q        <= '0;
         seg_prev_q   <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         state_q      <= HUNT;
         expect_q     <= '0;
         digit_seg_q  <= '0;
         cur_digit_q  <= '0;
         frame_done_q <= 1'b0;
         anode_err_q  <= 1'b0;
         seq_err_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         anode_q      <= anode_n;
         anode_prev_q <= anode_q;
         seg_q        <= seg_d;
         seg_prev_q   <= seg_q;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         state_q      <= state_d;
         expect_q     <= expect_d;
         digit_seg_q  <= digit_seg_d;
         cur_digit_q  <= cur_digit_d;
         frame_done_q <= frame_done_d;
         anode_err_q  <= anode_err_d;
         seq_err_q    <= seq_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign digit_seg  = digit_seg_q;
   assign cur_digit  = cur_digit_q;
   assign frame_done = frame_done_q;
   assign locked     = (state_q == TRACK);
   assign anode_err  = anode_err_q;
   assign seq_err    = seq_err_q;
   assign err_count  = err_count_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: vector table, hand sequences and random scans against a history-based model.
module tb_seg_scan_capture;
   localparam int SETTLE = 2;
   localparam int ERRW   = 8;
`ifdef CAPTURE_DP_EN
   localparam logic [7:0] MSK = 8'hFF;
`else
   localparam logic [7:0] MSK = 8'h7F;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      anode_n, seg_n;
   logic [63:0]     digit_seg;
   logic [2:0]      cur_digit;
   logic            frame_done, locked, anode_err, seq_err;
   logic [ERRW-1:0] err_count;

   always #5 clk = ~clk;

   seg_scan_capture #(.SETTLE(SETTLE), .ERRW(ERRW)) dut (
      .clk(clk), .rst(rst), .anode_n(anode_n), .seg_n(seg_n),
      .digit_seg(digit_seg), .cur_digit(cur_digit), .frame_done(frame_done),
      .locked(locked), .anode_err(anode_err), .seq_err(seq_err), .err_count(err_count));

   int total = 0;
   int bad   = 0;
   int frames = 0;

   // Reference: a capture happens one cycle after a valid code has been sampled SETTLE+2 times in a row.
   logic [7:0]  m_dig [8];
   int          m_cur, m_exp, m_errc, m_run, pend_idx;
   bit          m_locked, m_frame, m_aerr, m_serr, pend_cap, pend_aerr;
   logic [7:0]  pend_seg;
   logic [15:0] m_prev;

   function automatic int onehot_idx(input logic [7:0] a);
      int n = 0;
      int ix = -1;
      for (int i = 0; i < 8; i++) if (!a[i]) begin n++; ix = i; end
      return (n == 1) ? ix : -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
      m_cur = 0; m_exp = 0; m_errc = 0; m_run = 1;
      m_locked = 0; m_frame = 0; m_aerr = 0; m_serr = 0;
      pend_cap = 0; pend_aerr = 0; pend_idx = 0; pend_seg = 8'h00;
      m_prev = {8'hFF, 8'h00};
   endtask

   task automatic model_edge(input logic [7:0] a, input logic [7:0] s);
      logic [7:0] sa;
      int ix;
      m_frame = 0; m_serr = 0;
      if (pend_cap) begin
         m_dig[pend_idx] = pend_seg;
         m_cur = pend_idx;
         if (!m_locked) begin
            if (pend_idx == 0) begin m_locked = 1; m_exp = 1; end
         end else if (pend_idx == m_exp) begin
            if (pend_idx == 7) m_frame = 1;
            m_exp = (m_exp + 1) % 8;
         end else begin
            m_serr = 1; m_locked = 0;
         end
      end
      m_aerr = pend_aerr;
      if ((m_aerr || m_serr) && m_errc < (1 << ERRW) - 1) m_errc++;
      sa = ~s & MSK;
      ix = onehot_idx(a);
      if ({a, sa} == m_prev) m_run++; else m_run = 1;
      pend_aerr = (ix < 0) && (a != 8'hFF) && (a != m_prev[15:8]);
      pend_cap  = (m_run == SETTLE + 2) && (ix >= 0);
      pend_idx  = (ix < 0) ? 0 : ix;
      pend_seg  = sa;
      m_prev    = {a, sa};
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[8*i +: 8] = m_dig[i];
      chk("digit_seg", digit_seg, d);
      chk("cur_digit", 64'(cur_digit), 64'(m_cur));
      chk("frame_done", 64'(frame_done), 64'(m_frame));
      chk("locked", 64'(locked), 64'(m_locked));
      chk("anode_err", 64'(anode_err), 64'(m_aerr));
      chk("seq_err", 64'(seq_err), 64'(m_serr));
      chk("err_count", 64'(err_count), 64'(m_errc));
      if (frame_done) frames++;
   endtask

   task automatic step(input logic [7:0] a, input logic [7:0] s);
      anode_n = a;
      seg_n   = s;
      @(posedge clk);
      if (rst) model_reset(); else model_edge(a, s);
      #2;
      check_all();
   endtask

   task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
      for (int k = 0; k < n; k++) step(a, s);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] s;
      int         dwell;
      int         cur;
      bit         lk;
      int         errc;
      logic [7:0] byt;
   } vec_t;
   vec_t tbl [15];

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] a, s, dp_exp;
      int last, dw, r;
      // Blank-separated scan, a short dwell, a wrong-order digit, an illegal code, then relock.
      for (int i = 0; i < 8; i++)
         tbl[i] = '{8'(~(8'h01 << i)), 8'(~(8'h10 + i)), 4, i, 1'b1, 0, 8'(8'h10 + i)};
      tbl[8]  = '{8'hFE, 8'hEF, 4, 0, 1'b1, 0, 8'h10};
      tbl[9]  = '{8'hFD, 8'hEE, 4, 1, 1'b1, 0, 8'h11};
      tbl[10] = '{8'hFB, 8'hED, 4, 2, 1'b1, 0, 8'h12};
      tbl[11] = '{8'hF7, 8'hEC, 1, 2, 1'b1, 0, 8'h12};
      tbl[12] = '{8'hEF, 8'hEB, 4, 4, 1'b0, 1, 8'h14};
      tbl[13] = '{8'hFC, 8'h00, 5, 4, 1'b0, 2, 8'h14};
      tbl[14] = '{8'hFE, 8'hDF, 4, 0, 1'b1, 2, 8'h20};

      rst = 1'b1; anode_n = 8'hFF; seg_n = 8'hFF;
      model_reset();
      #12;
      check_all();
      @(posedge clk); #2; rst = 1'b0;

      // Back-to-back rotation, no blanks: two full frames.
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 8; i++) hold(8'(~(8'h01 << i)), 8'(~(8'h10 + i)), 4);
      hold(8'hFF, 8'hFF, 2);
      chk("rot_frames", 64'(frames), 64'd2);
      chk("rot_digits", digit_seg, 64'h1716151413121110);
      chk("rot_errs", 64'(err_count), 64'd0);

      for (int v = 0; v < 15; v++) begin
         hold(tbl[v].a, tbl[v].s, tbl[v].dwell);
         hold(8'hFF, 8'hFF, 2);
         chk($sformatf("tbl%0d_cur", v), 64'(cur_digit), 64'(tbl[v].cur));
         chk($sformatf("tbl%0d_lock", v), 64'(locked), 64'(tbl[v].lk));
         chk($sformatf("tbl%0d_errc", v), 64'(err_count), 64'(tbl[v].errc));
         chk($sformatf("tbl%0d_byte", v), 64'(digit_seg[8*tbl[v].cur +: 8]), 64'(tbl[v].byt));
      end
      chk("tbl_frames", 64'(frames), 64'd3);

      // Decimal point: active-high 8'hC0 on digit 1.
`ifdef CAPTURE_DP_EN
      dp_exp = 8'hC0;
`else
      dp_exp = 8'h40;
`endif
      hold(8'hFD, 8'h3F, 4);
      hold(8'hFF, 8'hFF, 2);
      chk("dp_byte", 64'(digit_seg[15:8]), 64'(dp_exp));

      // Asynchronous reset in the middle of digit 5, then resume and relock at digit 0.
      for (int i = 2; i < 5; i++) hold(8'(~(8'h01 << i)), 8'(~(8'h30 + i)), 4);
      hold(8'hDF, 8'hCA, 2);
      #3 rst = 1'b1;
      #1;
      chk("rst_digit_seg", digit_seg, 64'd0);
      chk("rst_cur", 64'(cur_digit), 64'd0);
      chk("rst_flags", 64'({frame_done, locked, anode_err, seq_err}), 64'd0);
      chk("rst_errc", 64'(err_count), 64'd0);
      step(8'hDF, 8'hCA);
      rst = 1'b0;
      hold(8'hBF, 8'hC9, 4);
      hold(8'h7F, 8'hC8, 4);
      hold(8'hFE, 8'hC7, 4);
      hold(8'hFD, 8'hC6, 4);
      hold(8'hFF, 8'hFF, 2);
      chk("relock_locked", 64'(locked), 64'd1);
      chk("relock_cur", 64'(cur_digit), 64'd1);

      // Random scans with glitches, blanks, illegal codes and DP activity.
      last = 7;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70) begin last = (last + 1) % 8; a = 8'(~(8'h01 << last)); end
         else if (r < 80) a = 8'hFF;
         else if (r < 90) a = 8'(~(8'h01 << $urandom_range(0, 7)));
         else a = 8'($urandom);
         s  = 8'($urandom);
         dw = $urandom_range(1, 6);
         for (int k = 0; k < dw; k++) begin
            if ($urandom_range(0, 9) == 0) s = 8'($urandom);
            step(a, s);
         end
      end

      // 300 transitions into an illegal code saturate the error counter.
      for (int n = 0; n < 300; n++) begin
         step(8'hFC, 8'h00);
         step(8'hFF, 8'hFF);
      end
      chk("sat_errc", 64'(err_count), 64'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
